// File: rtl/acc_pkg.sv
// Shared constants and FSM encoding for the accumulator drain path.
package acc_pkg;

    localparam int DEF_DEPTH      = 8;
    localparam int DEF_ARRAY_M    = 8;
    localparam int DEF_DATA_WIDTH = 32;
    localparam int ACC_RD_LAT     = 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    function automatic int idx_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/stream_skid_buf.sv
// Two-entry stream buffer with fall-through when empty; upstream never pushes
// into a full buffer because the producer meters pushes against count.
module stream_skid_buf #(
    parameter int WIDTH = 257
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       count
);

    logic [WIDTH-1:0] mem [2];
    logic             wr_ptr;
    logic             rd_ptr;
    logic [1:0]       count_q;
    logic             pop;
    logic             store;
    logic             deq;

    // A beat transfers on any cycle with out_valid & out_ready; out_valid never
    // drops and out_data never changes while out_valid & !out_ready.
    assign out_valid = (count_q != 2'd0) || in_valid;
    assign out_data  = (count_q != 2'd0) ? mem[rd_ptr] : (in_valid ? in_data : '0);
    assign pop       = out_valid & out_ready;

    // An incoming beat consumed straight through an empty buffer is never stored.
    assign store = in_valid & !((count_q == 2'd0) && pop);
    assign deq   = pop & (count_q != 2'd0);
    assign count = count_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem[0]  <= '0;
            mem[1]  <= '0;
            wr_ptr  <= 1'b0;
            rd_ptr  <= 1'b0;
            count_q <= 2'd0;
        end else begin
            if (store) begin
                mem[wr_ptr] <= in_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (deq) begin
                rd_ptr <= ~rd_ptr;
            end
            count_q <= count_q + {1'b0, store} - {1'b0, deq};
        end
    end

endmodule

// File: rtl/acc_drain_reader.sv
// Sweeps accumulator rows 0..num_rows-1 and streams each row out as one beat,
// metering reads against buffer space so no returned row is ever dropped.
module acc_drain_reader
    import acc_pkg::*;
#(
    parameter int DEPTH          = DEF_DEPTH,
    parameter int ARRAY_M        = DEF_ARRAY_M,
    parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int IDX_WIDTH      = idx_width(DEPTH),
    parameter int IDX_SET_WIDTH  = IDX_WIDTH * ARRAY_M,
    parameter int DATA_SET_WIDTH = ARRAY_M * DATA_WIDTH
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [IDX_WIDTH:0]        num_rows,
    output logic                      busy,
    output logic                      done,
    output logic                      drain,
    output logic [ARRAY_M-1:0]        enable_set,
    output logic [IDX_SET_WIDTH-1:0]  idx_set,
    input  logic [DATA_SET_WIDTH-1:0] acc_out,
    output logic                      m_valid,
    input  logic                      m_ready,
    output logic [DATA_SET_WIDTH-1:0] m_data,
    output logic                      m_last,
    output state_t                    dbg_state,
    output logic [1:0]                dbg_buf_count,
    output logic                      dbg_inflight
);

    localparam logic [IDX_WIDTH:0] MAX_ROWS = (IDX_WIDTH + 1)'(DEPTH);

    state_t               state_q;
    state_t               state_d;
    logic [IDX_WIDTH:0]   rows_q;
    logic [IDX_WIDTH:0]   rows_clamped;
    logic [IDX_WIDTH-1:0] rd_idx_q;
    logic [IDX_WIDTH-1:0] last_idx_q;
    logic                 inflight_q;
    logic                 inflight_last_q;
    logic [1:0]           buf_count;
    logic [2:0]           occupancy;
    logic                 pop;
    logic                 credit_ok;
    logic                 issue;
    logic                 is_last_row;

    assign rows_clamped = (num_rows > MAX_ROWS) ? MAX_ROWS : num_rows;
    assign is_last_row  = ({1'b0, rd_idx_q} == (rows_q - 1'b1));
    assign pop          = m_valid & m_ready;

    // The row in flight plus buffered rows, minus the one leaving now, must leave a free slot.
    assign occupancy = {2'b00, inflight_q} + {1'b0, buf_count};
    assign credit_ok = occupancy < (3'd2 + {2'b00, pop});

    always_comb begin
        state_d = state_q;
        issue   = 1'b0;
        busy    = 1'b0;
        done    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = (rows_clamped == '0) ? ST_DONE : ST_READ;
                end
            end
            ST_READ: begin
                busy  = 1'b1;
                issue = credit_ok;
                if (credit_ok && is_last_row) begin
                    state_d = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                busy = 1'b1;
                // The tagged last beat leaving now is the final handshake of the sweep.
                if (pop && m_last) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q         <= ST_IDLE;
            rows_q          <= '0;
            rd_idx_q        <= '0;
            last_idx_q      <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            inflight_q      <= issue;
            inflight_last_q <= issue & is_last_row;
            if (state_q == ST_IDLE && start) begin
                rows_q   <= rows_clamped;
                rd_idx_q <= '0;
            end else if (issue) begin
                rd_idx_q   <= rd_idx_q + 1'b1;
                last_idx_q <= rd_idx_q;
            end
        end
    end

    assign drain      = issue;
    assign enable_set = {ARRAY_M{issue}};
    assign idx_set    = {ARRAY_M{issue ? rd_idx_q : last_idx_q}};

    stream_skid_buf #(
        .WIDTH (DATA_SET_WIDTH + 1)
    ) u_skid (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (inflight_q),
        .in_data   ({inflight_last_q, acc_out}),
        .out_valid (m_valid),
        .out_ready (m_ready),
        .out_data  ({m_last, m_data}),
        .count     (buf_count)
    );

    assign dbg_state     = state_q;
    assign dbg_buf_count = buf_count;
    assign dbg_inflight  = inflight_q;

endmodule

// File: tb/tb_acc_drain_reader.sv
// Directed bench for acc_drain_reader with a 1-cycle registered accumulator model.
module tb_acc_drain_reader;
    import acc_pkg::*;

    localparam int DEPTH = 8;
    localparam int AM    = 8;
    localparam int DW    = 32;
    localparam int IW    = 3;
    localparam int DSW   = AM * DW;

    logic           clk;
    logic           reset;
    logic           start;
    logic [IW:0]    num_rows;
    logic           busy;
    logic           done;
    logic           drain;
    logic [AM-1:0]  enable_set;
    logic [IW*AM-1:0] idx_set;
    logic [DSW-1:0] acc_out;
    logic           m_valid;
    logic           m_ready;
    logic [DSW-1:0] m_data;
    logic           m_last;
    state_t         dbg_state;
    logic [1:0]     dbg_buf_count;
    logic           dbg_inflight;

    logic [DSW:0] exp_q[$];
    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int beats, lasts, drains, dones, first_beat_cyc, last_beat_cyc, done_cyc;
    int s;
    logic stall_prev;
    logic [DSW:0] prev_beat;
    logic repulsed;
    logic st;

    acc_drain_reader dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .num_rows      (num_rows),
        .busy          (busy),
        .done          (done),
        .drain         (drain),
        .enable_set    (enable_set),
        .idx_set       (idx_set),
        .acc_out       (acc_out),
        .m_valid       (m_valid),
        .m_ready       (m_ready),
        .m_data        (m_data),
        .m_last        (m_last),
        .dbg_state     (dbg_state),
        .dbg_buf_count (dbg_buf_count),
        .dbg_inflight  (dbg_inflight)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // accumulator model: entry[r][i] = 100*r + i, read data one cycle after drain
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_out <= '0;
        end else if (drain) begin
            for (int i = 0; i < AM; i++) begin
                acc_out[i*DW +: DW] <= DW'(100 * int'(idx_set[i*IW +: IW]) + i);
            end
        end
    end

    function automatic logic [DSW-1:0] row_word(input int r);
        logic [DSW-1:0] w;
        for (int i = 0; i < AM; i++) begin
            w[i*DW +: DW] = DW'(100 * r + i);
        end
        return w;
    endfunction

    task automatic chk(input string tag, input logic [263:0] obs, input logic [263:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic push_exp(input int n);
        int m;
        m = (n > DEPTH) ? DEPTH : n;
        for (int r = 0; r < m; r++) begin
            exp_q.push_back({(r == m - 1), row_word(r)});
        end
    endtask

    task automatic clear_stats();
        beats = 0; lasts = 0; drains = 0; dones = 0;
        first_beat_cyc = -1; last_beat_cyc = -1; done_cyc = -1;
    endtask

    // driver + per-cycle scoreboard: drive at the falling edge, then observe settled values
    task automatic tick(input logic rdy, input logic stv, input logic [IW:0] n);
        @(negedge clk);
        m_ready  = rdy;
        start    = stv;
        num_rows = n;
        #1;
        cyc++;
        chk("credit", ((32'(dbg_buf_count) + 32'(dbg_inflight)) <= 2), 1'b1);
        chk("enable_set", enable_set, drain ? {AM{1'b1}} : {AM{1'b0}});
        if (drain) begin
            drains++;
            chk("drain_state", dbg_state, ST_READ);
        end
        if (stall_prev) begin
            chk("stable", {m_valid, m_last, m_data}, {1'b1, prev_beat});
        end
        if (m_valid && m_ready) begin
            chk("beat_expected", (exp_q.size() != 0), 1'b1);
            if (exp_q.size() != 0) begin
                chk("beat", {m_last, m_data}, exp_q.pop_front());
            end
            if (beats == 0) first_beat_cyc = cyc;
            last_beat_cyc = cyc;
            beats++;
            if (m_last) lasts++;
        end
        if (done) begin
            dones++;
            done_cyc = cyc;
        end
        stall_prev = m_valid && !m_ready && !reset;
        prev_beat  = {m_last, m_data};
    endtask

    // mode 0: ready held high, mode 1: ready toggles 1,0,1,0...
    task automatic wait_done(input int mode, input int max_cyc);
        logic rdy;
        for (int j = 0; j < max_cyc; j++) begin
            rdy = (mode == 0) ? 1'b1 : (j % 2 == 0);
            tick(rdy, 1'b0, '0);
            if (done) break;
        end
        chk("done_seen", done, 1'b1);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; m_ready = 1'b0; num_rows = '0;
        stall_prev = 1'b0; prev_beat = '0;
        clear_stats();
        repeat (3) @(negedge clk);
        #1;
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_drain", drain, 1'b0);
        chk("rst_m_valid", m_valid, 1'b0);
        chk("rst_m_last", m_last, 1'b0);
        chk("rst_enable_set", enable_set, '0);
        chk("rst_idx_set", idx_set, '0);
        chk("rst_m_data", m_data, '0);
        chk("rst_state", dbg_state, ST_IDLE);
        reset = 1'b0;

        // 1: full sweep, ready held high
        clear_stats();
        tick(1'b1, 1'b1, 4'd8);
        s = cyc;
        push_exp(8);
        chk("t1_busy", busy, 1'b0);
        wait_done(0, 100);
        chk("t1_first_lat", first_beat_cyc, s + 2);
        chk("t1_back_to_back", last_beat_cyc - first_beat_cyc, 7);
        chk("t1_done_lat", done_cyc, last_beat_cyc + 1);
        chk("t1_beats", beats, 8);
        chk("t1_lasts", lasts, 1);
        chk("t1_busy_after", busy, 1'b0);
        chk("t1_q_empty", exp_q.size(), 0);

        // 2: ready toggling
        clear_stats();
        tick(1'b1, 1'b1, 4'd8);
        push_exp(8);
        wait_done(1, 200);
        chk("t2_beats", beats, 8);
        chk("t2_lasts", lasts, 1);
        chk("t2_q_empty", exp_q.size(), 0);

        // 3: long stall then release
        clear_stats();
        tick(1'b0, 1'b1, 4'd8);
        push_exp(8);
        repeat (20) tick(1'b0, 1'b0, '0);
        chk("t3_stall_drains", drains, 2);
        chk("t3_stall_beats", beats, 0);
        wait_done(0, 100);
        chk("t3_drains", drains, 8);
        chk("t3_beats", beats, 8);
        chk("t3_q_empty", exp_q.size(), 0);

        // 4: zero rows, single row, clamped row count
        clear_stats();
        tick(1'b1, 1'b1, 4'd0);
        s = cyc;
        wait_done(0, 10);
        chk("t4_zero_done_lat", done_cyc, s + 1);
        chk("t4_zero_drains", drains, 0);
        chk("t4_zero_beats", beats, 0);
        clear_stats();
        tick(1'b1, 1'b1, 4'd1);
        push_exp(1);
        wait_done(0, 20);
        chk("t4_one_beats", beats, 1);
        chk("t4_one_lasts", lasts, 1);
        clear_stats();
        tick(1'b1, 1'b1, 4'd12);
        push_exp(12);
        wait_done(0, 100);
        chk("t4_clamp_beats", beats, 8);
        chk("t4_clamp_q_empty", exp_q.size(), 0);

        // 5a: start re-pulsed mid-sweep is ignored
        clear_stats();
        tick(1'b1, 1'b1, 4'd8);
        push_exp(8);
        repulsed = 1'b0;
        for (int j = 0; j < 100; j++) begin
            st = (beats == 3) && !repulsed;
            if (st) repulsed = 1'b1;
            tick(1'b1, st, 4'd2);
            if (done) break;
        end
        chk("t5_repulse_beats", beats, 8);
        chk("t5_repulse_dones", dones, 1);
        chk("t5_repulse_q_empty", exp_q.size(), 0);

        // 5b: reset mid-sweep aborts, then a fresh sweep
        clear_stats();
        tick(1'b1, 1'b1, 4'd8);
        push_exp(8);
        for (int j = 0; j < 100; j++) begin
            tick(1'b1, 1'b0, '0);
            if (beats == 4) break;
        end
        reset = 1'b1;
        #1;
        chk("t5_rst_m_valid", m_valid, 1'b0);
        chk("t5_rst_drain", drain, 1'b0);
        chk("t5_rst_busy", busy, 1'b0);
        chk("t5_rst_m_data", m_data, '0);
        chk("t5_rst_m_last", m_last, 1'b0);
        chk("t5_rst_idx_set", idx_set, '0);
        chk("t5_rst_buf_count", dbg_buf_count, 2'd0);
        chk("t5_rst_state", dbg_state, ST_IDLE);
        exp_q.delete();
        stall_prev = 1'b0;
        repeat (3) tick(1'b1, 1'b0, '0);
        chk("t5_rst_no_done", dones, 0);
        reset = 1'b0;
        clear_stats();
        tick(1'b1, 1'b1, 4'd8);
        s = cyc;
        push_exp(8);
        wait_done(0, 100);
        chk("t5_after_first_lat", first_beat_cyc, s + 2);
        chk("t5_after_beats", beats, 8);
        chk("t5_after_lasts", lasts, 1);
        chk("t5_after_q_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
